// File: rtl/sdram_ctrl_pkg.sv
// Shared definitions for the SDRAM init/refresh controller: host command
// encodings, init sequencer states and a width helper.
package sdram_ctrl_pkg;

  localparam logic [1:0] CMD_NOP    = 2'b00;
  localparam logic [1:0] CMD_READA  = 2'b01;
  localparam logic [1:0] CMD_WRITEA = 2'b10;

  typedef enum logic [2:0] {
    StWait,
    StPre,
    StRef,
    StMrs,
    StDone
  } init_state_e;

  // Smallest r with 2**r >= v.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/sdram_init_refresh_ctrl_if.sv
// Host/command-FSM facing signal bundle of the SDRAM init/refresh controller.
// slave is the controller side, master the side that drives CMD/ADDR/acks.
interface sdram_init_refresh_ctrl_if #(
  parameter int unsigned ASIZE = 23,
  parameter int unsigned PW    = 4
);
  logic [1:0]       CMD;
  logic [ASIZE-1:0] ADDR;
  logic             REF_ACK;
  logic             CM_ACK;
  logic             NOP;
  logic             READA;
  logic             WRITEA;
  logic [ASIZE-1:0] SADDR;
  logic             PRECHARGE;
  logic             REFRESH;
  logic             LOAD_MODE;
  logic             INIT_REQ;
  logic             INIT_DONE;
  logic             CMD_ACK;
  logic             REF_REQ;
  logic             REF_URGENT;
  logic             REF_OVF;
  logic [PW-1:0]    REF_PENDING;

  modport slave (
    input  CMD, ADDR, REF_ACK, CM_ACK,
    output NOP, READA, WRITEA, SADDR, PRECHARGE, REFRESH, LOAD_MODE, INIT_REQ, INIT_DONE,
           CMD_ACK, REF_REQ, REF_URGENT, REF_OVF, REF_PENDING
  );

  modport master (
    output CMD, ADDR, REF_ACK, CM_ACK,
    input  NOP, READA, WRITEA, SADDR, PRECHARGE, REFRESH, LOAD_MODE, INIT_REQ, INIT_DONE,
           CMD_ACK, REF_REQ, REF_URGENT, REF_OVF, REF_PENDING
  );
endinterface

// File: rtl/sdram_refresh_scheduler.sv
// Periodic refresh tick timer with a saturating backlog of postponed refreshes.
// Idle (and deaf to ref_ack) until enable rises.
module sdram_refresh_scheduler #(
  parameter int unsigned REF_PER      = 1024,
  parameter int unsigned REF_MAX_PEND = 8,
  parameter int unsigned TW           = 16,
  parameter int unsigned PW           = 4
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          enable,
  input  logic          ref_ack,
  output logic          ref_req,
  output logic          ref_urgent,
  output logic          ref_ovf,
  output logic [PW-1:0] ref_pending
);

  localparam logic [TW-1:0] Reload  = TW'(REF_PER - 1);
  localparam logic [PW-1:0] PendMax = PW'(REF_MAX_PEND);

  logic [TW-1:0] timer_q;
  logic [PW-1:0] pend_q;
  logic          ovf_q;
  logic          tick;
  logic          ack;

  assign tick = enable && (timer_q == '0);
  assign ack  = enable && ref_ack;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      timer_q <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else if (!enable) begin
      // Preload so the first tick lands REF_PER cycles after enable rises.
      timer_q <= Reload;
    end else begin
      timer_q <= tick ? Reload : timer_q - 1'b1;
      if (tick && !ack) begin
        if (pend_q == PendMax) ovf_q <= 1'b1;
        else                   pend_q <= pend_q + 1'b1;
      end else if (ack && !tick && (pend_q != '0)) begin
        pend_q <= pend_q - 1'b1;
      end
    end
  end

  assign ref_req     = (pend_q != '0);
  assign ref_urgent  = (pend_q == PendMax);
  assign ref_ovf     = ovf_q;
  assign ref_pending = pend_q;

endmodule

// File: rtl/sdram_init_refresh_ctrl.sv
// Host command register/decoder, SDRAM power-up sequencer and refresh
// backlog scheduler sitting in front of the SDRAM command FSM.
module sdram_init_refresh_ctrl
  import sdram_ctrl_pkg::*;
#(
  parameter int unsigned ASIZE        = 23,
  parameter int unsigned INIT_PER     = 24000,
  parameter int unsigned INIT_STEP    = 20,
  parameter int unsigned INIT_REF_CNT = 8,
  parameter int unsigned REF_PER      = 1024,
  parameter int unsigned REF_MAX_PEND = 8,
  parameter int unsigned TW           = 16
) (
  input logic                      CLK,
  input logic                      RESET,
  sdram_init_refresh_ctrl_if.slave bus
);

  localparam int unsigned PW = clog2(REF_MAX_PEND + 1);

  localparam longint unsigned InitSpan =
      longint'(INIT_PER) + longint'(INIT_REF_CNT + 3) * longint'(INIT_STEP);
  localparam longint unsigned CntLimit = 64'd1 << TW;

  if (InitSpan >= CntLimit) begin : g_chk_init_width
    $error("init sequence length does not fit in TW-bit counters");
  end
  if (longint'(REF_PER) >= CntLimit || REF_PER < 1) begin : g_chk_ref_width
    $error("REF_PER must be nonzero and fit in TW bits");
  end
  if (INIT_STEP < 2 || INIT_REF_CNT < 1 || REF_MAX_PEND < 1) begin : g_chk_ranges
    $error("INIT_STEP >= 2, INIT_REF_CNT >= 1 and REF_MAX_PEND >= 1 are required");
  end

  // WAIT keeps counting one extra step past INIT_PER so each state issues its
  // command on entry and then dwells INIT_STEP cycles.
  localparam logic [TW-1:0] InitPerCnt = TW'(INIT_PER);
  localparam logic [TW-1:0] WaitEnd    = TW'(INIT_PER + INIT_STEP - 1);
  localparam logic [TW-1:0] StepEnd    = TW'(INIT_STEP - 1);
  localparam logic [TW-1:0] RefLast    = TW'(INIT_REF_CNT - 1);

  init_state_e   state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] rcnt_q, rcnt_d;

  logic init_req, precharge, refresh, load_mode, init_done;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= StWait;
      cnt_q   <= '0;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rcnt_q  <= rcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    rcnt_d  = rcnt_q;
    unique case (state_q)
      StWait: begin
        if (cnt_q == WaitEnd) begin
          state_d = StPre;
          cnt_d   = '0;
        end
      end
      StPre: begin
        if (cnt_q == StepEnd) begin
          state_d = StRef;
          cnt_d   = '0;
        end
      end
      StRef: begin
        if (cnt_q == StepEnd) begin
          cnt_d = '0;
          if (rcnt_q == RefLast) state_d = StMrs;
          else                   rcnt_d  = rcnt_q + 1'b1;
        end
      end
      StMrs: begin
        if (cnt_q == StepEnd) begin
          state_d = StDone;
          cnt_d   = '0;
        end
      end
      StDone: begin
        cnt_d = cnt_q;
      end
      default: begin
        state_d = StWait;
        cnt_d   = '0;
        rcnt_d  = '0;
      end
    endcase
  end

  always_comb begin
    init_req  = (state_q == StWait) && (cnt_q < InitPerCnt);
    precharge = (state_q == StPre) && (cnt_q == '0);
    refresh   = (state_q == StRef) && (cnt_q == '0);
    load_mode = (state_q == StMrs) && (cnt_q == '0);
    init_done = (state_q == StDone);
  end

  logic             nop_q, reada_q, writea_q, cmd_ack_q;
  logic             nop_d, reada_d, writea_d;
  logic [ASIZE-1:0] saddr_q;

  // Host commands are masked to NOP until the SDRAM is initialised.
  always_comb begin
    nop_d    = 1'b1;
    reada_d  = 1'b0;
    writea_d = 1'b0;
    if (init_done) begin
      nop_d    = (bus.CMD == CMD_NOP);
      reada_d  = (bus.CMD == CMD_READA);
      writea_d = (bus.CMD == CMD_WRITEA);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      nop_q     <= 1'b1;
      reada_q   <= 1'b0;
      writea_q  <= 1'b0;
      saddr_q   <= '0;
      cmd_ack_q <= 1'b0;
    end else begin
      nop_q     <= nop_d;
      reada_q   <= reada_d;
      writea_q  <= writea_d;
      saddr_q   <= bus.ADDR;
      cmd_ack_q <= bus.CM_ACK & ~cmd_ack_q;
    end
  end

  logic          ref_req, ref_urgent, ref_ovf;
  logic [PW-1:0] ref_pending;

  sdram_refresh_scheduler #(
    .REF_PER      (REF_PER),
    .REF_MAX_PEND (REF_MAX_PEND),
    .TW           (TW),
    .PW           (PW)
  ) u_ref_sched (
    .CLK         (CLK),
    .RESET       (RESET),
    .enable      (init_done),
    .ref_ack     (bus.REF_ACK),
    .ref_req     (ref_req),
    .ref_urgent  (ref_urgent),
    .ref_ovf     (ref_ovf),
    .ref_pending (ref_pending)
  );

  assign bus.NOP         = nop_q;
  assign bus.READA       = reada_q;
  assign bus.WRITEA      = writea_q;
  assign bus.SADDR       = saddr_q;
  assign bus.CMD_ACK     = cmd_ack_q;
  assign bus.PRECHARGE   = precharge;
  assign bus.REFRESH     = refresh;
  assign bus.LOAD_MODE   = load_mode;
  assign bus.INIT_REQ    = init_req;
  assign bus.INIT_DONE   = init_done;
  assign bus.REF_REQ     = ref_req;
  assign bus.REF_URGENT  = ref_urgent;
  assign bus.REF_OVF     = ref_ovf;
  assign bus.REF_PENDING = ref_pending;

endmodule

// File: tb/tb_sdram_init_refresh_ctrl.sv
// Self-checking bench: per-cycle reference model driven by cycle arithmetic,
// plus table vectors and directed sequences for init timing and refresh corners.
module tb_sdram_init_refresh_ctrl;
  import sdram_ctrl_pkg::*;

  localparam int AW    = 23;
  localparam int IPER  = 100;
  localparam int ISTEP = 10;
  localparam int IREF  = 2;
  localparam int RPER  = 50;
  localparam int MAXP  = 4;
  localparam int TWID  = 16;
  localparam int PW    = int'(clog2(MAXP + 1));
  localparam int DoneT = IPER + (IREF + 3) * ISTEP;

  logic CLK = 1'b0;
  logic RESET = 1'b1;

  sdram_init_refresh_ctrl_if #(.ASIZE(AW), .PW(PW)) bus ();

  sdram_init_refresh_ctrl #(
    .ASIZE        (AW),
    .INIT_PER     (IPER),
    .INIT_STEP    (ISTEP),
    .INIT_REF_CNT (IREF),
    .REF_PER      (RPER),
    .REF_MAX_PEND (MAXP),
    .TW           (TWID)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_fail = 0;
  int t = 0;      // cycles since reset release
  int run = 0;    // length of current CM_ACK high run
  bit m_nop = 1'b1, m_rd = 1'b0, m_wr = 1'b0, m_ack = 1'b0, m_ovf = 1'b0;
  logic [AW-1:0] m_saddr = '0;
  int m_pend = 0;

  typedef struct {
    int t;
    bit rq;
    bit pr;
    bit rf;
    bit lm;
    bit dn;
  } init_vec_t;

  typedef struct {
    logic [1:0]    cmd;
    logic [AW-1:0] addr;
    bit            nop;
    bit            rd;
    bit            wr;
  } dec_vec_t;

  init_vec_t iv[11];
  dec_vec_t  dv[4];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at t=%0d: got %0h, expected %0h", nm, t, act, exp);
    end
  endtask

  task automatic check_model();
    chk("INIT_REQ", bus.INIT_REQ, t < IPER);
    chk("PRECHARGE", bus.PRECHARGE, t == IPER + ISTEP);
    chk("REFRESH", bus.REFRESH, (t >= IPER + 2 * ISTEP) && (t <= IPER + (IREF + 1) * ISTEP)
                                && ((t - IPER) % ISTEP == 0));
    chk("LOAD_MODE", bus.LOAD_MODE, t == IPER + (IREF + 2) * ISTEP);
    chk("INIT_DONE", bus.INIT_DONE, t >= DoneT);
    chk("NOP", bus.NOP, m_nop);
    chk("READA", bus.READA, m_rd);
    chk("WRITEA", bus.WRITEA, m_wr);
    chk("SADDR", bus.SADDR, m_saddr);
    chk("CMD_ACK", bus.CMD_ACK, m_ack);
    chk("REF_PENDING", bus.REF_PENDING, m_pend);
    chk("REF_REQ", bus.REF_REQ, m_pend != 0);
    chk("REF_URGENT", bus.REF_URGENT, m_pend == MAXP);
    chk("REF_OVF", bus.REF_OVF, m_ovf);
  endtask

  // Advance one clock, updating the model from the inputs seen at this edge.
  task automatic step();
    bit dn, tk, ak;
    int nt;
    if (RESET) begin
      m_nop = 1'b1; m_rd = 1'b0; m_wr = 1'b0; m_saddr = '0; m_ack = 1'b0;
      m_pend = 0; m_ovf = 1'b0; run = 0; nt = 0;
    end else begin
      dn = (t >= DoneT);
      nt = t + 1;
      m_saddr = bus.ADDR;
      m_nop = !dn || (bus.CMD == 2'b00);
      m_rd  = dn && (bus.CMD == 2'b01);
      m_wr  = dn && (bus.CMD == 2'b10);
      run   = bus.CM_ACK ? run + 1 : 0;
      m_ack = bus.CM_ACK && (run % 2 == 1);
      tk = (nt > DoneT) && ((nt - DoneT) % RPER == 0);
      ak = dn && bus.REF_ACK;
      if (tk && !ak) begin
        if (m_pend == MAXP) m_ovf = 1'b1;
        else                m_pend++;
      end else if (ak && !tk && m_pend > 0) begin
        m_pend--;
      end
    end
    @(posedge CLK);
    #1;
    t = nt;
    check_model();
  endtask

  task automatic rand_inputs(input bit ref_en, input int ack_pct);
    bus.CMD     = 2'($urandom_range(0, 3));
    bus.ADDR    = AW'($urandom);
    bus.CM_ACK  = 1'($urandom_range(0, 1));
    bus.REF_ACK = ref_en && ($urandom_range(0, 99) < ack_pct);
  endtask

  task automatic check_reset_state();
    chk("rst INIT_REQ", bus.INIT_REQ, 1);
    chk("rst NOP", bus.NOP, 1);
    chk("rst READA", bus.READA, 0);
    chk("rst WRITEA", bus.WRITEA, 0);
    chk("rst SADDR", bus.SADDR, 0);
    chk("rst PRECHARGE", bus.PRECHARGE, 0);
    chk("rst REFRESH", bus.REFRESH, 0);
    chk("rst LOAD_MODE", bus.LOAD_MODE, 0);
    chk("rst INIT_DONE", bus.INIT_DONE, 0);
    chk("rst CMD_ACK", bus.CMD_ACK, 0);
    chk("rst REF_PENDING", bus.REF_PENDING, 0);
    chk("rst REF_OVF", bus.REF_OVF, 0);
  endtask

  task automatic check_init_tbl();
    foreach (iv[i]) begin
      if (iv[i].t == t) begin
        chk("tbl INIT_REQ", bus.INIT_REQ, iv[i].rq);
        chk("tbl PRECHARGE", bus.PRECHARGE, iv[i].pr);
        chk("tbl REFRESH", bus.REFRESH, iv[i].rf);
        chk("tbl LOAD_MODE", bus.LOAD_MODE, iv[i].lm);
        chk("tbl INIT_DONE", bus.INIT_DONE, iv[i].dn);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ack_exp[4];
    int pct[3];
    ack_exp = '{1'b1, 1'b0, 1'b1, 1'b0};
    pct     = '{0, 2, 60};
    iv = '{
      '{0,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
      '{99,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
      '{100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
      '{109, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
      '{110, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0},
      '{111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
      '{120, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0},
      '{130, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0},
      '{140, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0},
      '{149, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
      '{150, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}
    };
    dv = '{
      '{2'b01, 23'h001234, 1'b0, 1'b1, 1'b0},
      '{2'b10, 23'h7fffff, 1'b0, 1'b0, 1'b1},
      '{2'b11, 23'h000001, 1'b0, 1'b0, 1'b0},
      '{2'b00, 23'h2aaaaa, 1'b1, 1'b0, 1'b0}
    };

    bus.CMD = CMD_NOP; bus.ADDR = '0; bus.REF_ACK = 1'b0; bus.CM_ACK = 1'b0;
    RESET = 1'b1;
    repeat (3) step();
    check_reset_state();
    RESET = 1'b0;

    // Reset in the middle of the init refresh burst restarts everything.
    while (t < 125) begin rand_inputs(1'b1, 30); step(); end
    RESET = 1'b1;
    step();
    check_reset_state();
    check_init_tbl();
    RESET = 1'b0;

    // Full init timeline, WRITEA requested throughout and masked.
    while (t < DoneT) begin
      rand_inputs(1'b1, 30);
      bus.CMD = CMD_WRITEA;
      step();
      check_init_tbl();
      if (t == 50) begin
        chk("pre-init WRITEA", bus.WRITEA, 0);
        chk("pre-init NOP", bus.NOP, 1);
      end
    end

    bus.CM_ACK = 1'b0; bus.REF_ACK = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.CMD = dv[i].cmd; bus.ADDR = dv[i].addr;
      step();
      chk("dec NOP", bus.NOP, dv[i].nop);
      chk("dec READA", bus.READA, dv[i].rd);
      chk("dec WRITEA", bus.WRITEA, dv[i].wr);
      chk("dec SADDR", bus.SADDR, dv[i].addr);
    end

    bus.CM_ACK = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("held CM_ACK", bus.CMD_ACK, ack_exp[i]);
    end
    bus.CM_ACK = 1'b0;

    // Unserviced backlog climbs to saturation, then a lost tick sets overflow.
    while (t < 400) begin
      rand_inputs(1'b0, 0);
      step();
      if (t >= 200 && t % RPER == 0)
        chk("backlog", bus.REF_PENDING, ((t - DoneT) / RPER > MAXP) ? MAXP : (t - DoneT) / RPER);
      if (t == 350) chk("urgent at sat", bus.REF_URGENT, 1);
      if (t == 399) chk("ovf before lost tick", bus.REF_OVF, 0);
    end
    chk("ovf on lost tick", bus.REF_OVF, 1);
    chk("pending held at sat", bus.REF_PENDING, MAXP);

    RESET = 1'b1;
    repeat (2) step();
    check_reset_state();
    RESET = 1'b0;

    while (t < 160) begin rand_inputs(1'b0, 0); step(); end
    bus.REF_ACK = 1'b1;
    step();
    chk("ack at empty pending", bus.REF_PENDING, 0);
    chk("ack at empty REF_REQ", bus.REF_REQ, 0);
    bus.REF_ACK = 1'b0;

    while (t < 299) begin rand_inputs(1'b0, 0); step(); end
    bus.REF_ACK = 1'b1;
    step();
    chk("ack with tick pending", bus.REF_PENDING, 2);
    chk("ack with tick ovf", bus.REF_OVF, 0);
    bus.REF_ACK = 1'b0;

    for (int i = 0; i < 900; i++) begin
      rand_inputs(1'b1, pct[(i / 300) % 3]);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_init_refresh_ctrl.md
Name: sdram_init_refresh_ctrl

Overview:
- Parametrised successor to the SDRAM control interface.
- Registers and decodes host commands and sequences the SDRAM power-up: wait, precharge-all, N auto-refreshes, mode-register load.
- Schedules periodic refresh with a bounded backlog of postponed refreshes, an urgency flag and an overflow flag.
- Sits between the host command port and the SDRAM command FSM; all init step counts and spacings are parameters.

Parameters:
- ASIZE, 23, host address width.
- INIT_PER, 24000, power-up wait in cycles (INIT_REQ high time).
- INIT_STEP, 20, cycles between consecutive init commands; must be ≥2.
- INIT_REF_CNT, 8, auto-refreshes issued during init; must be ≥1.
- REF_PER, 1024, cycles between refresh ticks.
- REF_MAX_PEND, 8, maximum postponed-refresh backlog; must be ≥1.
- TW, 16, width of the internal init and refresh counters.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- CMD  in  2  host command: 00 NOP, 01 READA, 10 WRITEA, 11 reserved.
- ADDR  in  ASIZE  host address.
- REF_ACK  in  1  one-cycle pulse: command FSM has issued one refresh.
- CM_ACK  in  1  command acknowledge from the command FSM.
- NOP, READA, WRITEA  out  1 each  decoded, registered command.
- SADDR  out  ASIZE  registered ADDR, aligned with the decoded command.
- PRECHARGE, REFRESH, LOAD_MODE  out  1 each  init command pulses.
- INIT_REQ  out  1  high during the power-up wait.
- INIT_DONE  out  1  sticky high once init completes.
- CMD_ACK  out  1  acknowledge pulse to the host.
- REF_REQ  out  1  refresh backlog is non-zero.
- REF_URGENT  out  1  backlog equals REF_MAX_PEND.
- REF_OVF  out  1  sticky: a refresh tick was lost at saturation.
- REF_PENDING  out  clog2(REF_MAX_PEND+1)  current backlog count.

Behaviour:
- Reset: all registers are synchronous on CLK. INIT_REQ=1 and NOP=1; every other output and counter is 0.
- Reset asserted at any time, including mid-init, restarts the full sequence on the next edge.
- Decode, 1-cycle latency:
  - SADDR<=ADDR every cycle.
  - NOP/READA/WRITEA are one-hot from CMD; CMD=11 drives all three to 0.
  - While INIT_DONE=0, READA and WRITEA are forced to 0 and NOP to 1.
- CMD_ACK: CMD_ACK<=CM_ACK & ~CMD_ACK, so a held CM_ACK toggles CMD_ACK.
- Init FSM states: WAIT → PRE → REF → MRS → DONE.
  - WAIT: INIT_REQ=1 for INIT_PER cycles after reset release. t0 is the first cycle with INIT_REQ=0.
  - PRECHARGE pulses high for 1 cycle at t0+INIT_STEP.
  - REFRESH pulse k (k=1..INIT_REF_CNT) occurs at t0+(k+1)*INIT_STEP; a refresh counter selects the REF→MRS transition.
  - LOAD_MODE pulses at t0+(INIT_REF_CNT+2)*INIT_STEP.
  - INIT_DONE rises at t0+(INIT_REF_CNT+3)*INIT_STEP and stays high until reset.
  - All init pulses are exactly 1 cycle and mutually exclusive.
- Refresh scheduler:
  - Held idle, with REF_ACK ignored, until INIT_DONE=1.
  - A down-counter loads REF_PER-1, ticks when it reaches 0, then reloads. First tick is REF_PER cycles after INIT_DONE rises.
  - Tick only: pending+1, saturating at REF_MAX_PEND. A tick at saturation sets REF_OVF; pending stays at REF_MAX_PEND.
  - REF_ACK only: pending-1, floor 0. REF_ACK at pending=0 has no effect.
  - Tick and REF_ACK in the same cycle: pending is unchanged, and REF_OVF is not set.
  - REF_REQ=(pending≠0) and REF_URGENT=(pending==REF_MAX_PEND), both derived from the registered count, so they have no extra latency.
- Width rule: all counters are TW bits. INIT_PER+(INIT_REF_CNT+3)*INIT_STEP and REF_PER must each fit in TW bits; the implementation checks this and errors at elaboration.

Decomposition:
- Shared package sdram_ctrl_pkg holds:
  - CMD encodings (CMD_NOP, CMD_READA, CMD_WRITEA);
  - the init-state enumeration;
  - a clog2 function for the REF_PENDING width.
- One sub-module, sdram_refresh_scheduler: tick timer, backlog counter, REF_REQ/REF_URGENT/REF_OVF. Its inputs are enable=INIT_DONE, REF_ACK and the parameters.
- Decode, ack and the init FSM stay in the top module.

Test Plan:
- Bench parameters: INIT_PER=100, INIT_STEP=10, INIT_REF_CNT=2, REF_PER=50, REF_MAX_PEND=4.
- Release RESET at cycle 0 → INIT_REQ high for cycles 0–99; PRECHARGE at 110; REFRESH at 120 and 130; LOAD_MODE at 140; INIT_DONE high from 150; no other pulses.
- CMD=10 before INIT_DONE → WRITEA stays 0, NOP=1. After INIT_DONE, CMD=01 with ADDR=0x001234 → next cycle READA=1 and SADDR=0x001234. CMD=11 → NOP/READA/WRITEA all 0.
- No REF_ACK after INIT_DONE → REF_PENDING=1,2,3,4 at cycles 200,250,300,350; REF_URGENT at 350; at 400 REF_OVF sets and REF_PENDING stays 4.
- REF_ACK coincident with a tick at pending=2 → pending stays 2. REF_ACK at pending=0 → stays 0 and REF_REQ=0.
- CM_ACK held high for 4 cycles → CMD_ACK sequence 1,0,1,0.
- RESET asserted at cycle 125 for 1 cycle → next edge: INIT_REQ=1, all else 0. The sequence then restarts, with PRECHARGE 110 cycles after release.
